// File: rtl/acc_feed_pkg.sv
// Shared types and constants for the accumulator command feeder.
package acc_feed_pkg;

  localparam int unsigned CMD_DATA_W = 16;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned RPT_W      = 3;

  // Accumulator operation encoding
  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_AND = 2'd2;
  localparam logic [OP_W-1:0] OP_OR  = 2'd3;

  // The accumulator updates every cycle, so "no operation" is OR with zero
  localparam logic [OP_W-1:0]       NOP_SEL  = OP_OR;
  localparam logic [CMD_DATA_W-1:0] NOP_DATA = '0;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [CMD_DATA_W-1:0] data;
    logic [RPT_W-1:0]      rpt;
  } acc_cmd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } feed_state_e;

endpackage

// File: rtl/acc_cmd_fifo.sv
// Command FIFO for the feeder: power-of-two depth, registered count,
// combinational head read. Full-FIFO pushes and empty-FIFO pops are ignored.
module acc_cmd_fifo
  import acc_feed_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type cmd_t = acc_cmd_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  cmd_t             push_data_i,
  input  logic             pop_i,
  output cmd_t             head_c_o,
  output logic [CNT_W-1:0] count_o
);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify requests and compute next pointers/count; pointers wrap naturally
  always_comb begin
    do_push  = push_i && (count_q != CNT_W'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: rtl/acc_cmd_feeder.sv
// Accumulator command feeder: queues {op, data, rpt} commands and issues each
// rpt+1 times to the accumulator stage, driving NOP (OR 0) when idle.
// Optional feature: define ACC_FEED_STALL_EN to add a stall input that holds
// the issue sequence and drives NOP on stalled cycles.
module acc_cmd_feeder
  import acc_feed_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef ACC_FEED_STALL_EN
  input  logic              stall,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [2:0]        cmd_rpt,
  output logic [1:0]        acc_sel,
  output logic [DATA_W-1:0] acc_in,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  feed_state_e           state_q, state_d;
  logic [RPT_W-1:0]      rem_q, rem_d;
  logic [OP_W-1:0]       cur_op_q, cur_op_d;
  logic [CMD_DATA_W-1:0] cur_data_q, cur_data_d;
  logic [OP_W-1:0]       sel_q, sel_d;
  logic [DATA_W-1:0]     in_q, in_d;

  acc_cmd_t              push_cmd;
  acc_cmd_t              head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic                  stall_w;

`ifdef ACC_FEED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Accept when the registered count has room and reset is released
  assign cmd_ready = reset && (fifo_count < CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{op: cmd_op, data: CMD_DATA_W'(cmd_data), rpt: cmd_rpt};
  assign busy      = (fifo_count != '0) || (rem_q != '0);

  acc_cmd_fifo #(
    .DEPTH (DEPTH),
    .cmd_t (acc_cmd_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_c_o    (head),
    .count_o     (fifo_count)
  );

  // One issue slot per unstalled edge: repeat current, else pop head, else NOP
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cur_op_d   = cur_op_q;
    cur_data_d = cur_data_q;
    sel_d      = NOP_SEL;
    in_d       = DATA_W'(NOP_DATA);
    pop        = 1'b0;
    if (!stall_w) begin
      unique case (state_q)
        ST_ISSUE: begin
          if (rem_q != '0) begin
            sel_d = cur_op_q;
            in_d  = DATA_W'(cur_data_q);
            rem_d = rem_q - RPT_W'(1);
          end else if (fifo_count != '0) begin
            pop        = 1'b1;
            cur_op_d   = head.op;
            cur_data_d = head.data;
            sel_d      = head.op;
            in_d       = DATA_W'(head.data);
            rem_d      = head.rpt;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            cur_op_d   = head.op;
            cur_data_d = head.data;
            sel_d      = head.op;
            in_d       = DATA_W'(head.data);
            rem_d      = head.rpt;
            state_d    = ST_ISSUE;
          end
        end
      endcase
    end
  end

  // State and registered accumulator outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      cur_op_q   <= NOP_SEL;
      cur_data_q <= NOP_DATA;
      sel_q      <= NOP_SEL;
      in_q       <= DATA_W'(NOP_DATA);
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cur_op_q   <= cur_op_d;
      cur_data_q <= cur_data_d;
      sel_q      <= sel_d;
      in_q       <= in_d;
    end
  end

  assign acc_sel = sel_q;
  assign acc_in  = in_q;

endmodule

// File: tb/tb_acc_cmd_feeder.sv
// Scoreboard bench for acc_cmd_feeder: every accepted command queues rpt+1
// expected issues; a negedge monitor pops them as non-NOP outputs appear.
`timescale 1ns/1ps
module tb_acc_cmd_feeder;
  import acc_feed_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_tb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [2:0]  cmd_rpt;
  logic [1:0]  acc_sel;
  logic [15:0] acc_in;
  logic        busy;

  logic [17:0] sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          issued_cnt = 0;
  bit          issuing = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] acc_model = '0;

  always #5 clock = ~clock;

  acc_cmd_feeder #(.DATA_W(16), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef ACC_FEED_STALL_EN
    .stall     (stall_tb),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_rpt   (cmd_rpt),
    .acc_sel   (acc_sel),
    .acc_in    (acc_in),
    .busy      (busy)
  );

  always @(posedge clock) stall_prev <= stall_tb;

  // Scoreboard monitor and downstream accumulator model
  always @(negedge clock) begin
    logic        is_nop;
    logic [17:0] exp_v;
    is_nop = (acc_sel == NOP_SEL) && (acc_in == 16'h0000);
    case (acc_sel)
      2'd0:    acc_model = acc_model + acc_in;
      2'd1:    acc_model = acc_model - acc_in;
      2'd2:    acc_model = acc_model & acc_in;
      default: acc_model = acc_model | acc_in;
    endcase
    if (issuing && sb.size() != 0 && !stall_prev && reset) begin
      vectors++;
      if (is_nop) begin
        miscompares++;
        $display("FAIL no_gap: got NOP, required sel=%0d data=%h", sb[0][17:16], sb[0][15:0]);
      end
    end
    if (!is_nop) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got sel=%0d data=%h, required NOP", acc_sel, acc_in);
      end else begin
        exp_v = sb.pop_front();
        if ({acc_sel, acc_in} !== exp_v) begin
          miscompares++;
          $display("FAIL issue_order: got sel=%0d data=%h, required sel=%0d data=%h",
                   acc_sel, acc_in, exp_v[17:16], exp_v[15:0]);
        end
        issued_cnt++;
        issuing = (sb.size() != 0);
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Present a command until accepted; queue its expected issues on acceptance
  task automatic push_cmd(input logic [1:0] op, input logic [15:0] data,
                          input logic [2:0] rpt, output int waited);
    bit ok;
    ok        = 1'b0;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_rpt   = rpt;
    while (!ok && waited < 100) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        for (int r = 0; r <= int'(rpt); r++) sb.push_back({op, data});
      end else begin
        waited++;
      end
      cycle();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL push_timeout: got no accept in %0d cycles, required accept", waited);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending issues, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_rpt   = '0;
    stall_tb  = 1'b0;
    repeat (2) cycle();
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_in_reset: got %b, required 0", cmd_ready);
    end
    vectors++;
    if ({acc_sel, acc_in} !== {NOP_SEL, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_nop: got sel=%0d data=%h, required sel=3 data=0000", acc_sel, acc_in);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({acc_sel, acc_in, busy, cmd_ready} !== {NOP_SEL, 16'h0000, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL idle_%0d: got sel=%0d data=%h busy=%b ready=%b, required 3 0000 0 1",
                 i, acc_sel, acc_in, busy, cmd_ready);
      end
    end
  endtask

  task automatic test_repeat();
    int w;
    acc_model = '0;
    push_cmd(OP_ADD, 16'h0005, 3'd2, w);
    vectors++;
    if ({acc_sel, acc_in} !== {NOP_SEL, 16'h0000}) begin
      miscompares++;
      $display("FAIL latency_nop: got sel=%0d data=%h, required NOP", acc_sel, acc_in);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({acc_sel, acc_in, busy} !== {OP_ADD, 16'h0005, (i < 2) ? 1'b1 : 1'b0}) begin
        miscompares++;
        $display("FAIL repeat_%0d: got sel=%0d data=%h busy=%b, required 0 0005 %b",
                 i, acc_sel, acc_in, busy, (i < 2));
      end
    end
    cycle();
    vectors++;
    if ({acc_sel, acc_in} !== {NOP_SEL, 16'h0000}) begin
      miscompares++;
      $display("FAIL repeat_end_nop: got sel=%0d data=%h, required NOP", acc_sel, acc_in);
    end
    drain();
    vectors++;
    if (acc_model !== 16'h000F) begin
      miscompares++;
      $display("FAIL acc_total: got %h, required 000F", acc_model);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int start;
    logic [1:0]  ops [5];
    logic [15:0] dat [5];
    ops = '{OP_SUB, OP_AND, OP_OR, OP_ADD, OP_SUB};
    dat = '{16'h0011, 16'hFF0F, 16'h0A00, 16'h1234, 16'h0003};
    start = issued_cnt;
    push_cmd(OP_ADD, 16'h0101, 3'd7, w);
    cycle();
    for (int k = 0; k < 4; k++) begin
      push_cmd(ops[k], dat[k], 3'd0, w);
      vectors++;
      if (w != 0) begin
        miscompares++;
        $display("FAIL fill_wait_%0d: got %0d wait cycles, required 0", k, w);
      end
    end
    vectors++;
    if ({cmd_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL ready_full: got ready=%b busy=%b, required ready=0 busy=1", cmd_ready, busy);
    end
    push_cmd(ops[4], dat[4], 3'd0, w);
    vectors++;
    if (w == 0) begin
      miscompares++;
      $display("FAIL fifth_wait: got %0d wait cycles, required more than 0", w);
    end
    drain();
    vectors++;
    if (issued_cnt - start != 13) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d issues, required 13", issued_cnt - start);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int start;
    start = issued_cnt;
    push_cmd(OP_SUB, 16'h0001, 3'd7, w);
    repeat (3) cycle();
    @(negedge clock);
    #1;
    vectors++;
    if (issued_cnt - start != 3) begin
      miscompares++;
      $display("FAIL pre_reset_issues: got %0d, required 3", issued_cnt - start);
    end
    reset = 1'b0;
    sb.delete();
    issuing = 1'b0;
    cycle();
    vectors++;
    if ({acc_sel, acc_in, busy, cmd_ready} !== {NOP_SEL, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: got sel=%0d data=%h busy=%b ready=%b, required 3 0000 0 0",
               acc_sel, acc_in, busy, cmd_ready);
    end
    reset = 1'b1;
    cycle();
    vectors++;
    if ({acc_sel, acc_in, busy, cmd_ready} !== {NOP_SEL, 16'h0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset: got sel=%0d data=%h busy=%b ready=%b, required 3 0000 0 1",
               acc_sel, acc_in, busy, cmd_ready);
    end
    repeat (4) cycle();
  endtask

  task automatic test_wrap();
    int w;
    int start;
    start = issued_cnt;
    for (int i = 0; i < 12; i++) begin
      push_cmd(2'(i % 4), 16'(16'h1111 * (i + 1)), 3'd0, w);
      vectors++;
      if (w != 0) begin
        miscompares++;
        $display("FAIL wrap_wait_%0d: got %0d wait cycles, required 0", i, w);
      end
    end
    drain();
    vectors++;
    if (issued_cnt - start != 12) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d issues, required 12", issued_cnt - start);
    end
  endtask

`ifdef ACC_FEED_STALL_EN
  task automatic test_stall();
    int w;
    push_cmd(OP_OR, 16'h00F0, 3'd1, w);
    cycle();
    vectors++;
    if ({acc_sel, acc_in} !== {OP_OR, 16'h00F0}) begin
      miscompares++;
      $display("FAIL stall_first: got sel=%0d data=%h, required 3 00F0", acc_sel, acc_in);
    end
    stall_tb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if ({acc_sel, acc_in, busy} !== {NOP_SEL, 16'h0000, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_nop_%0d: got sel=%0d data=%h busy=%b, required 3 0000 1",
                 i, acc_sel, acc_in, busy);
      end
    end
    stall_tb = 1'b0;
    cycle();
    vectors++;
    if ({acc_sel, acc_in, busy} !== {OP_OR, 16'h00F0, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_resume: got sel=%0d data=%h busy=%b, required 3 00F0 0",
               acc_sel, acc_in, busy);
    end
    cycle();
    vectors++;
    if ({acc_sel, acc_in} !== {NOP_SEL, 16'h0000}) begin
      miscompares++;
      $display("FAIL stall_end_nop: got sel=%0d data=%h, required NOP", acc_sel, acc_in);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
`ifdef ACC_FEED_STALL_EN
    test_stall();
`endif
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000ns, required finish");
    $fatal(1);
  end

endmodule
